if_prefetch: RTL and testbench
==============================

Name: if_prefetch

Overview:
- Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue of {pc, instruction} pairs.
- Issues sequential word fetches over a req/ok memory handshake and presents queued instructions to decode under a stall signal.
- Handles EX-stage redirects by flushing the queue and discarding any in-flight response.
- Sits between the memory controller and ID.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, prefetch queue entries (power of two, >=2)
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
mem_req  out  1  fetch request, registered
mem_addr  out  XLEN  fetch address, registered, stable while mem_req=1 and mem_ok=0
mem_ok  in  1  response valid; completes the outstanding request
mem_data  in  XLEN  fetched word, valid with mem_ok
ex_if_pce  in  1  redirect strobe from EX
ex_if_pc  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
stl  in  1  decode stall; head is not consumed while 1
id_valid  out  1  queue head valid (count != 0)
id_pc  out  XLEN  pc of head entry
id_is  out  XLEN  instruction of head entry

Behaviour:
- Reset (rst=0, async):
  - mem_req=0, mem_addr=0, fpc=RESET_PC.
  - Queue empty; id_valid=0, id_pc=0, id_is=0; state IDLE.
- Internal state:
  - fpc: next address to issue.
  - At most one outstanding request.
- Issue:
  - On issue, mem_req<=1, mem_addr<=fpc, fpc<=fpc+4 (mod 2^XLEN).
  - Allowed when count_next < DEPTH, where count_next is the queue count after this cycle's enqueue/dequeue.
  - No request is ever issued without a guaranteed slot.
- Protocol:
  - mem_req stays 1 with unchanged mem_addr until mem_ok. Withdrawal is forbidden, including after a redirect.
  - mem_ok while mem_req=0 is ignored.
- FSM IDLE:
  - Issue when space is available; go to BUSY.
  - With ex_if_pce=1, issue uses ex_if_pc (mem_addr<=target, fpc<=target+4).
- FSM BUSY, mem_ok=1, no redirect:
  - Enqueue {mem_addr, mem_data}.
  - If space remains, issue back-to-back (mem_req stays 1, new address) and stay BUSY.
  - Otherwise mem_req<=0 and go to IDLE.
- FSM BUSY, redirect without mem_ok:
  - Flush the queue; fpc<=target; go to DROP.
  - mem_req/mem_addr are held.
- FSM BUSY, redirect with mem_ok in the same cycle:
  - Discard the response and flush.
  - Issue the target immediately; stay BUSY.
- FSM DROP:
  - On mem_ok, discard the data and issue fpc; go to BUSY.
  - A further redirect updates fpc only; stay DROP.
- Dequeue:
  - Occurs when id_valid=1 and stl=0; the head advances at the edge.
  - Enqueue and dequeue in the same cycle are allowed at any fill level, including full.
- Redirect priority:
  - Redirect beats enqueue and dequeue; a same-cycle dequeue is void.
  - id_valid=0 the cycle after a redirect.
- Latency:
  - The enqueued entry is visible on id_* the cycle after mem_ok; there is no bypass.
  - With a 1-cycle memory, steady-state throughput is 1 instruction per 2 cycles. Memory that holds mem_ok high across back-to-back requests gives 1/cycle.
- Full queue:
  - mem_req drops after the last response.
  - Re-issue happens the same cycle a dequeue frees a slot.
- Mid-operation reset: all state returns to reset values immediately. Any response arriving after reset release while mem_req=0 is ignored.

Decomposition:
- Package if_pkg: state enum {IDLE, BUSY, DROP}, XLEN default, the ILEN=4 byte increment constant.
- Sub-module if_queue: circular buffer with parameterised DEPTH and width 2*XLEN.
  - Ports: push, pop, flush, head outputs, count.
  - Wrap-around uses ptr width clog2(DEPTH) plus a count register.

Test Plan:
- Reset release, 1-cycle memory, stl=0:
  - mem_addr sequence 0,4,8,12.
  - id_pc/id_is pairs match memory contents, in order, with no duplicates.
- stl=1 held, DEPTH=4:
  - Exactly 4 requests complete, then mem_req=0 with the queue full.
  - Deassert stl: one dequeue per cycle; mem_req reasserts with addr 16 in the same cycle the first slot frees.
- Redirect to 0x100 while a request to 0x8 is outstanding, mem_ok 3 cycles later:
  - mem_addr held at 0x8 until ok; the 0x8 data never appears on id_*.
  - Next request is 0x100; id_valid=0 from the cycle after the redirect.
- Redirect to 0x200 coincident with mem_ok and a dequeue:
  - Response and dequeue both dropped; the next-cycle request is 0x200; the first id_pc afterward is 0x200.
- Redirect to 0x103:
  - Fetch at 0x100; id_pc=0x100.
- Assert rst=0 mid-BUSY asynchronously:
  - Outputs go to reset values immediately.
  - After release, the first fetch is at RESET_PC; a stale mem_ok is ignored.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
package if_pkg;
   localparam int XLEN_DEFAULT = 32;
   localparam int ILEN         = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DROP = 2'd2
   } state_t;
endpackage

// File: rtl/if_queue.sv
// Circular prefetch buffer: power-of-two depth, separate count so full and empty are distinct.
module if_queue #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [W-1:0]           data_i,
   output logic [W-1:0]           head_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  buf_q [DEPTH];
   logic [PW-1:0] rd_q;
   logic [PW-1:0] wr_q;
   logic [CW-1:0] count_q;

   // Storage, pointers and occupancy; flush only rewinds bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= '0;
         end
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            buf_q[wr_q] <= data_i;
            wr_q        <= wr_q + PW'(1);
         end
         if (pop_i) begin
            rd_q <= rd_q + PW'(1);
         end
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign head_o  = buf_q[rd_q];
   assign count_o = count_q;
endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: sequential word prefetch into a queue, with redirect flush and response drop.
module if_prefetch
   import if_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ok,
   input  logic [XLEN-1:0] mem_data,
   input  logic            ex_if_pce,
   input  logic [XLEN-1:0] ex_if_pc,
   input  logic            stl,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_is
);
   localparam int CW = $clog2(DEPTH) + 1;

   state_t          state_q;
   logic            mem_req_q;
   logic [XLEN-1:0] mem_addr_q;
   logic [XLEN-1:0] fpc_q;

   logic [CW-1:0]     count_s;
   logic [CW-1:0]     count_next_s;
   logic [2*XLEN-1:0] head_s;
   logic [XLEN-1:0]   tgt_s;
   logic              ok_s;
   logic              push_s;
   logic              pop_s;
   logic              space_s;

   assign tgt_s = {ex_if_pc[XLEN-1:2], 2'b00};
   assign ok_s  = mem_req_q & mem_ok;

   // Queue control: a redirect flushes and voids both the response and the dequeue.
   always_comb begin
      push_s = 1'b0;
      pop_s  = 1'b0;
      if (ex_if_pce) begin
         count_next_s = '0;
      end else begin
         push_s       = (state_q == BUSY) & ok_s;
         pop_s        = (count_s != '0) & ~stl;
         count_next_s = count_s + CW'(push_s) - CW'(pop_s);
      end
      space_s = (count_next_s < CW'(DEPTH));
   end

   // Fetch FSM; the single outstanding request is never withdrawn before mem_ok.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         fpc_q      <= RESET_PC;
      end else begin
         case (state_q)
            IDLE: begin
               if (ex_if_pce) begin
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= tgt_s;
                  fpc_q      <= tgt_s + XLEN'(ILEN);
                  state_q    <= BUSY;
               end else if (space_s) begin
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= fpc_q;
                  fpc_q      <= fpc_q + XLEN'(ILEN);
                  state_q    <= BUSY;
               end else begin
                  state_q <= IDLE;
               end
            end
            BUSY: begin
               if (ex_if_pce && ok_s) begin
                  mem_addr_q <= tgt_s;
                  fpc_q      <= tgt_s + XLEN'(ILEN);
               end else if (ex_if_pce) begin
                  fpc_q   <= tgt_s;
                  state_q <= DROP;
               end else if (ok_s) begin
                  if (space_s) begin
                     mem_addr_q <= fpc_q;
                     fpc_q      <= fpc_q + XLEN'(ILEN);
                  end else begin
                     mem_req_q <= 1'b0;
                     state_q   <= IDLE;
                  end
               end else begin
                  state_q <= BUSY;
               end
            end
            DROP: begin
               if (ok_s && ex_if_pce) begin
                  mem_addr_q <= tgt_s;
                  fpc_q      <= tgt_s + XLEN'(ILEN);
                  state_q    <= BUSY;
               end else if (ok_s) begin
                  mem_addr_q <= fpc_q;
                  fpc_q      <= fpc_q + XLEN'(ILEN);
                  state_q    <= BUSY;
               end else if (ex_if_pce) begin
                  fpc_q <= tgt_s;
               end else begin
                  state_q <= DROP;
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   if_queue #(
      .DEPTH (DEPTH),
      .W     (2 * XLEN)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .flush_i (ex_if_pce),
      .data_i  ({mem_addr_q, mem_data}),
      .head_o  (head_s),
      .count_o (count_s)
   );

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign id_valid = (count_s != '0);
   assign id_pc    = head_s[2*XLEN-1:XLEN];
   assign id_is    = head_s[XLEN-1:0];
endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: memory responder plus per-scenario tasks with hand-derived expectations.
module tb_if_prefetch;
   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ok;
   logic [31:0] mem_data;
   logic        ex_if_pce;
   logic [31:0] ex_if_pc;
   logic        stl;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_is;

   int n_checks = 0;
   int n_fail   = 0;

   logic resp_en  = 1'b0;
   int   lat_cfg  = 1;
   int   wait_cnt = 0;

   logic [31:0] iss [16];
   int          n_iss;
   logic [31:0] cons_pc [16];
   logic [31:0] cons_is [16];
   int          n_cons;

   if_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ok    (mem_ok),
      .mem_data  (mem_data),
      .ex_if_pce (ex_if_pce),
      .ex_if_pc  (ex_if_pc),
      .stl       (stl),
      .id_valid  (id_valid),
      .id_pc     (id_pc),
      .id_is     (id_is)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: answers lat_cfg negedges after a request appears, one-cycle mem_ok pulse, data = ~addr.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst || !resp_en) begin
            wait_cnt = 0;
            if (resp_en) mem_ok = 1'b0;
         end else if (mem_ok) begin
            mem_ok   = 1'b0;
            wait_cnt = 0;
         end else if (mem_req) begin
            wait_cnt = wait_cnt + 1;
            if (wait_cnt >= lat_cfg) begin
               mem_ok   = 1'b1;
               mem_data = ~mem_addr;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input logic en, input int lat);
      tick();
      rst       = 1'b0;
      resp_en   = en;
      lat_cfg   = lat;
      mem_ok    = 1'b0;
      mem_data  = 32'h0;
      stl       = 1'b0;
      ex_if_pce = 1'b0;
      ex_if_pc  = 32'h0;
      tick();
      rst = 1'b1;
   endtask

   task automatic record(input int cycles);
      n_iss  = 0;
      n_cons = 0;
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (mem_req && n_iss < 16 && (n_iss == 0 || mem_addr != iss[n_iss-1])) begin
            iss[n_iss] = mem_addr;
            n_iss++;
         end
         if (id_valid && !stl && n_cons < 16) begin
            cons_pc[n_cons] = id_pc;
            cons_is[n_cons] = id_is;
            n_cons++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_ok = 1'b0; mem_data = 32'h0; stl = 1'b0; ex_if_pce = 1'b0; ex_if_pc = 32'h0;
      tick();
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %h exp 0", mem_req); end
      n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %h exp 0", id_valid); end
      n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", id_pc); end
      n_checks++; if (id_is !== 32'h0) begin n_fail++; $display("FAIL reset_is got %h exp 0", id_is); end
   endtask

   task automatic test_sequential();
      do_reset(1'b1, 1);
      record(12);
      n_checks++; if (n_cons < 4) begin n_fail++; $display("FAIL seq_count got %0d exp >=4", n_cons); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (iss[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr[%0d] got %h exp %h", i, iss[i], 32'(4 * i)); end
         n_checks++; if (cons_pc[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h exp %h", i, cons_pc[i], 32'(4 * i)); end
         n_checks++; if (cons_is[i] !== ~32'(4 * i)) begin n_fail++; $display("FAIL seq_is[%0d] got %h exp %h", i, cons_is[i], ~32'(4 * i)); end
      end
   endtask

   task automatic test_full();
      logic [31:0] exp_pc;
      do_reset(1'b1, 1);
      stl = 1'b1;
      record(12);
      n_checks++; if (n_iss !== 4) begin n_fail++; $display("FAIL full_reqs got %0d exp 4", n_iss); end
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_req got %h exp 0", mem_req); end
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %h exp 1", id_valid); end
      n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL full_head got %h exp 0", id_pc); end
      stl = 1'b0;
      tick();
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL refill_req got %h exp 1", mem_req); end
      n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL refill_addr got %h exp 10", mem_addr); end
      for (int i = 0; i < 4; i++) begin
         exp_pc = 32'(4 * (i + 1));
         if (i > 0) tick();
         n_checks++; if (id_pc !== exp_pc) begin n_fail++; $display("FAIL drain_pc[%0d] got %h exp %h", i, id_pc, exp_pc); end
      end
   endtask

   task automatic test_redirect_busy();
      do_reset(1'b0, 1);
      stl = 1'b1;
      tick(); mem_ok = 1'b1; mem_data = ~32'h0;
      tick(); mem_ok = 1'b0;
      tick(); mem_ok = 1'b1; mem_data = ~32'h4;
      tick(); mem_ok = 1'b0;
      n_checks++; if (mem_addr !== 32'h8) begin n_fail++; $display("FAIL rb_pre_addr got %h exp 8", mem_addr); end
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL rb_pre_valid got %h exp 1", id_valid); end
      ex_if_pce = 1'b1; ex_if_pc = 32'h100;
      tick(); ex_if_pce = 1'b0;
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rb_flush_valid got %h exp 0", id_valid); end
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rb_hold_req got %h exp 1", mem_req); end
      n_checks++; if (mem_addr !== 32'h8) begin n_fail++; $display("FAIL rb_hold_addr got %h exp 8", mem_addr); end
      tick();
      n_checks++; if (mem_addr !== 32'h8) begin n_fail++; $display("FAIL rb_hold_addr2 got %h exp 8", mem_addr); end
      tick(); mem_ok = 1'b1; mem_data = 32'hDEAD_BEEF;
      tick(); mem_ok = 1'b0;
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rb_new_req got %h exp 1", mem_req); end
      n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL rb_new_addr got %h exp 100", mem_addr); end
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rb_drop_valid got %h exp 0", id_valid); end
      tick(); mem_ok = 1'b1; mem_data = ~32'h100;
      tick(); mem_ok = 1'b0;
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL rb_tgt_valid got %h exp 1", id_valid); end
      n_checks++; if (id_pc !== 32'h100) begin n_fail++; $display("FAIL rb_tgt_pc got %h exp 100", id_pc); end
      n_checks++; if (id_is !== ~32'h100) begin n_fail++; $display("FAIL rb_tgt_is got %h exp %h", id_is, ~32'h100); end
      n_checks++; if (mem_addr !== 32'h104) begin n_fail++; $display("FAIL rb_next_addr got %h exp 104", mem_addr); end
   endtask

   task automatic test_redirect_ok();
      do_reset(1'b0, 1);
      tick(); mem_ok = 1'b1; mem_data = ~32'h0;
      tick();
      n_checks++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin n_fail++; $display("FAIL ro_pre_head got %h/%h exp 0/1", id_pc, id_valid); end
      n_checks++; if (mem_addr !== 32'h4) begin n_fail++; $display("FAIL ro_pre_addr got %h exp 4", mem_addr); end
      mem_ok = 1'b1; mem_data = ~32'h4; ex_if_pce = 1'b1; ex_if_pc = 32'h200;
      tick(); mem_ok = 1'b0; ex_if_pce = 1'b0;
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL ro_req got %h exp 1", mem_req); end
      n_checks++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL ro_addr got %h exp 200", mem_addr); end
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL ro_flush_valid got %h exp 0", id_valid); end
      tick();
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL ro_drop_valid got %h exp 0", id_valid); end
      mem_ok = 1'b1; mem_data = ~32'h200;
      tick(); mem_ok = 1'b0;
      n_checks++; if (id_pc !== 32'h200) begin n_fail++; $display("FAIL ro_tgt_pc got %h exp 200", id_pc); end
      n_checks++; if (id_is !== ~32'h200) begin n_fail++; $display("FAIL ro_tgt_is got %h exp %h", id_is, ~32'h200); end
   endtask

   task automatic test_misaligned();
      do_reset(1'b0, 1);
      ex_if_pce = 1'b1; ex_if_pc = 32'h103;
      tick(); ex_if_pce = 1'b0;
      n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL mis_addr got %h exp 100", mem_addr); end
      mem_ok = 1'b1; mem_data = ~32'h100;
      tick(); mem_ok = 1'b0;
      n_checks++; if (id_pc !== 32'h100) begin n_fail++; $display("FAIL mis_pc got %h exp 100", id_pc); end
      n_checks++; if (mem_addr !== 32'h104) begin n_fail++; $display("FAIL mis_next got %h exp 104", mem_addr); end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b1, 1);
      stl = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      #2 rst = 1'b0;
      #1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req got %h exp 0", mem_req); end
      n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_addr got %h exp 0", mem_addr); end
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %h exp 0", id_valid); end
      resp_en = 1'b0; mem_ok = 1'b1; mem_data = 32'h5A5A_5A5A;
      tick(); rst = 1'b1;
      tick(); mem_ok = 1'b0;
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_first got %h/%h exp 1/0", mem_req, mem_addr); end
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale got %h exp 0", id_valid); end
      tick(); mem_ok = 1'b1; mem_data = ~32'h0;
      tick(); mem_ok = 1'b0;
      n_checks++; if (id_valid !== 1'b1 || id_is !== ~32'h0) begin n_fail++; $display("FAIL mid_data got %h/%h exp 1/%h", id_valid, id_is, ~32'h0); end
      n_checks++; if (mem_addr !== 32'h4) begin n_fail++; $display("FAIL mid_next got %h exp 4", mem_addr); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_full();
      test_redirect_busy();
      test_redirect_ok();
      test_misaligned();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
